// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//
// Multi-cycle FETCH / DECODE / EXEC / WB sequencer for the 8-bit CPU. It owns
// the program counter and the instruction register, fetches instructions over
// a req/ack handshake, hands the opcode to the control unit and emits the
// per-instruction control-unit enable and writeback strobe.
//
// Optional feature macro: SEQ_TIMEOUT_EN
//   defined   : FETCH gives up after MAX_WAIT un-acked cycles and enters FAULT
//   undefined : FETCH waits indefinitely, Fault is tied to 0
//
// Ports:
//   Clk        in   rising-edge clock
//   Reset      in   asynchronous, active-high reset
//   Run        in   level; 1 = execute instructions
//   Imem_req   out  fetch request, high throughout FETCH
//   Imem_addr  out  fetch address (equals Pc)
//   Imem_ack   in   instruction memory returns data this cycle
//   Imem_data  in   instruction word, valid when Imem_ack = 1
//   Opcode     out  IR[7:5] to the control unit
//   Operand    out  IR[ADDR_W-1:0]
//   Cu_en      out  one-cycle control-unit enable in DECODE
//   Wb_strobe  out  one-cycle commit pulse in WB
//   Pc         out  current program counter
//   Busy       out  state is FETCH, DECODE, EXEC or WB
//   Halted     out  HALT state reached
//   Fault      out  fetch timeout (SEQ_TIMEOUT_EN only)
//   Dbg_state  out  encoded FSM state for observation
//
// Fetch handshake: Imem_req is high for every cycle spent in FETCH and
// Imem_addr is held at Pc for that whole time. A transfer completes on the
// rising edge where Imem_req and Imem_ack are both 1; Imem_data is captured on
// that edge. Imem_ack in any other state carries no meaning and is ignored.
// ---------------------------------------------------------------------------
module instr_sequencer #(
    parameter int ADDR_W   = 5,
    parameter int INSTR_W  = 8,
    parameter int MAX_WAIT = 15
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               Run,
    output logic               Imem_req,
    output logic [ADDR_W-1:0]  Imem_addr,
    input  logic               Imem_ack,
    input  logic [INSTR_W-1:0] Imem_data,
    output logic [2:0]         Opcode,
    output logic [ADDR_W-1:0]  Operand,
    output logic               Cu_en,
    output logic               Wb_strobe,
    output logic [ADDR_W-1:0]  Pc,
    output logic               Busy,
    output logic               Halted,
    output logic               Fault,
    output logic [2:0]         Dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_FAULT  = 3'd6
    } state_t;

    localparam logic [2:0] OP_JMP  = 3'b001;
    localparam logic [2:0] OP_HALT = 3'b111;

    state_t              state;
    state_t              state_nxt;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_nxt;
    logic [INSTR_W-1:0]  ir_q;
    logic                ir_load;

`ifdef SEQ_TIMEOUT_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_expired;

    // True in the FETCH cycle whose missing ack would bring the count to
    // MAX_WAIT; an ack in that same cycle still takes priority.
    assign wait_expired = (wait_cnt == CNT_W'(MAX_WAIT - 1));
`else
    // Parameter only meaningful with the timeout feature; a degenerate value
    // is tolerated here because nothing in this build depends on it.
    if (MAX_WAIT < 1) begin : g_max_wait_unused
    end
`endif

    // ------------------------------------------------------------------
    // State, PC and IR registers
    // ------------------------------------------------------------------
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state <= S_IDLE;
            pc_q  <= '0;
            ir_q  <= '0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            if (ir_load) begin
                ir_q <= Imem_data;
            end
        end
    end

`ifdef SEQ_TIMEOUT_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            wait_cnt <= '0;
        end else if (state_nxt == S_FETCH && state != S_FETCH) begin
            wait_cnt <= '0;
        end else if (state == S_FETCH && !Imem_ack) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end
`endif

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        ir_load   = 1'b0;
        case (state)
            S_IDLE: begin
                if (Run) begin
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: begin
                if (Imem_ack) begin
                    ir_load   = 1'b1;
                    state_nxt = S_DECODE;
                end
`ifdef SEQ_TIMEOUT_EN
                else if (wait_expired) begin
                    state_nxt = S_FAULT;
                end
`endif
            end
            S_DECODE: begin
                state_nxt = S_EXEC;
            end
            S_EXEC: begin
                // A jump retires here without a writeback cycle.
                if (Opcode == OP_JMP) begin
                    pc_nxt    = Operand;
                    state_nxt = Run ? S_FETCH : S_IDLE;
                end else if (Opcode == OP_HALT) begin
                    state_nxt = S_HALT;
                end else begin
                    state_nxt = S_WB;
                end
            end
            S_WB: begin
                // Natural ADDR_W-bit overflow gives the required wrap to 0.
                pc_nxt    = pc_q + ADDR_W'(1);
                state_nxt = Run ? S_FETCH : S_IDLE;
            end
            S_HALT: begin
                state_nxt = S_HALT;
            end
            S_FAULT: begin
                state_nxt = S_FAULT;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded straight from the state register, so an asynchronous
    // Reset removes Imem_req without waiting for a clock edge.
    // ------------------------------------------------------------------
    assign Imem_req  = (state == S_FETCH);
    assign Imem_addr = pc_q;
    assign Pc        = pc_q;
    assign Opcode    = ir_q[INSTR_W-1 -: 3];
    assign Operand   = ir_q[ADDR_W-1:0];
    assign Cu_en     = (state == S_DECODE);
    assign Wb_strobe = (state == S_WB);
    assign Busy      = (state == S_FETCH) || (state == S_DECODE) ||
                       (state == S_EXEC)  || (state == S_WB);
    assign Halted    = (state == S_HALT);
`ifdef SEQ_TIMEOUT_EN
    assign Fault     = (state == S_FAULT);
`else
    assign Fault     = 1'b0;
`endif
    assign Dbg_state = state;

endmodule

// File: tb/tb_instr_sequencer.sv
// ---------------------------------------------------------------------------
// tb_instr_sequencer
//
// Directed bench for instr_sequencer. A small instruction-memory model
// answers fetches after a programmable number of wait cycles; each scenario
// task drives the sequencer through instructions and checks the outputs one
// cycle at a time against hand-derived values.
// ---------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int ADDR_W   = 5;
    localparam int INSTR_W  = 8;
    localparam int MAX_WAIT = 15;

    localparam logic [2:0] ST_IDLE = 3'd0;

    logic               Clk;
    logic               Reset;
    logic               Run;
    logic               Imem_req;
    logic [ADDR_W-1:0]  Imem_addr;
    logic               Imem_ack;
    logic [INSTR_W-1:0] Imem_data;
    logic [2:0]         Opcode;
    logic [ADDR_W-1:0]  Operand;
    logic               Cu_en;
    logic               Wb_strobe;
    logic [ADDR_W-1:0]  Pc;
    logic               Busy;
    logic               Halted;
    logic               Fault;
    logic [2:0]         Dbg_state;

    int checks = 0;
    int errors = 0;

    // Instruction memory model
    logic [7:0] mem [32];
    int         ack_delay;
    logic       ack_enable;
    logic       ack_force;
    logic       data_force_en;
    logic [7:0] data_force;
    int         mem_wait;

    instr_sequencer #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .MAX_WAIT(MAX_WAIT)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Run      (Run),
        .Imem_req (Imem_req),
        .Imem_addr(Imem_addr),
        .Imem_ack (Imem_ack),
        .Imem_data(Imem_data),
        .Opcode   (Opcode),
        .Operand  (Operand),
        .Cu_en    (Cu_en),
        .Wb_strobe(Wb_strobe),
        .Pc       (Pc),
        .Busy     (Busy),
        .Halted   (Halted),
        .Fault    (Fault),
        .Dbg_state(Dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Memory answers once the request has been waiting ack_delay cycles.
    always @(posedge Clk or posedge Reset) begin
        if (Reset) mem_wait <= 0;
        else if (Imem_req && !Imem_ack) mem_wait <= mem_wait + 1;
        else mem_wait <= 0;
    end

    assign Imem_ack  = ack_force | (Imem_req & ack_enable & (mem_wait >= ack_delay));
    assign Imem_data = data_force_en ? data_force : mem[Imem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        Reset = 1'b1; Run = 1'b0;
        step(); step();
        checks++; if (Imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %b want 0", Imem_req); end
        checks++; if (Pc !== 5'd0) begin errors++; $display("FAIL rst_pc: got %0d want 0", Pc); end
        checks++; if ({Cu_en, Wb_strobe, Busy, Halted, Fault} !== 5'b0) begin errors++; $display("FAIL rst_flags: got %b want 00000", {Cu_en, Wb_strobe, Busy, Halted, Fault}); end
        checks++; if ({Opcode, Operand} !== 8'h00) begin errors++; $display("FAIL rst_ir: got %h want 00", {Opcode, Operand}); end
        checks++; if (Dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state: got %0d want 0", Dbg_state); end
        Reset = 1'b0;
        step();
        checks++; if (Imem_req !== 1'b0) begin errors++; $display("FAIL idle_no_run_req: got %b want 0", Imem_req); end
    endtask

    // mem[0]=0x45: opcode 010, operand 5, ack on the first FETCH cycle
    task automatic test_alu();
        Run = 1'b1;
        step();  // FETCH
        checks++; if (Imem_req !== 1'b1 || Imem_addr !== 5'd0) begin errors++; $display("FAIL alu_fetch: got req=%b addr=%0d want req=1 addr=0", Imem_req, Imem_addr); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL alu_busy: got %b want 1", Busy); end
        step();  // DECODE
        checks++; if (Cu_en !== 1'b1 || Imem_req !== 1'b0) begin errors++; $display("FAIL alu_decode: got cu_en=%b req=%b want 1 0", Cu_en, Imem_req); end
        checks++; if (Opcode !== 3'b010 || Operand !== 5'd5) begin errors++; $display("FAIL alu_ir: got op=%b opnd=%0d want 010 5", Opcode, Operand); end
        step();  // EXEC
        checks++; if (Cu_en !== 1'b0 || Wb_strobe !== 1'b0) begin errors++; $display("FAIL alu_exec: got cu_en=%b wb=%b want 0 0", Cu_en, Wb_strobe); end
        step();  // WB
        checks++; if (Wb_strobe !== 1'b1 || Pc !== 5'd0) begin errors++; $display("FAIL alu_wb: got wb=%b pc=%0d want 1 0", Wb_strobe, Pc); end
        step();  // FETCH of next instruction
        checks++; if (Wb_strobe !== 1'b0 || Pc !== 5'd1) begin errors++; $display("FAIL alu_pc: got wb=%b pc=%0d want 0 1", Wb_strobe, Pc); end
        checks++; if (Imem_req !== 1'b1 || Imem_addr !== 5'd1) begin errors++; $display("FAIL alu_next_fetch: got req=%b addr=%0d want 1 1", Imem_req, Imem_addr); end
    endtask

    // mem[1]=0x3A: JMP 26
    task automatic test_jmp();
        int cu_cnt;
        int wb_cnt;
        cu_cnt = 0; wb_cnt = 0;
        step();  // DECODE
        cu_cnt += int'(Cu_en); wb_cnt += int'(Wb_strobe);
        checks++; if (Opcode !== 3'b001 || Operand !== 5'd26) begin errors++; $display("FAIL jmp_ir: got op=%b opnd=%0d want 001 26", Opcode, Operand); end
        step();  // EXEC
        cu_cnt += int'(Cu_en); wb_cnt += int'(Wb_strobe);
        step();  // FETCH at target
        cu_cnt += int'(Cu_en); wb_cnt += int'(Wb_strobe);
        checks++; if (Pc !== 5'd26 || Imem_addr !== 5'd26 || Imem_req !== 1'b1) begin errors++; $display("FAIL jmp_target: got pc=%0d addr=%0d req=%b want 26 26 1", Pc, Imem_addr, Imem_req); end
        checks++; if (cu_cnt !== 1) begin errors++; $display("FAIL jmp_cu_pulses: got %0d want 1", cu_cnt); end
        checks++; if (wb_cnt !== 0) begin errors++; $display("FAIL jmp_wb_pulses: got %0d want 0", wb_cnt); end
    endtask

    // mem[26]=0x3F (JMP 31), mem[31]=0x00 NOP -> PC wraps to 0
    task automatic test_wrap();
        int wb_cnt;
        wb_cnt = 0;
        mem[0] = 8'h00;  // NOP
        mem[1] = 8'hE0;  // HALT
        step(); step(); step();  // DECODE, EXEC, FETCH at 31
        checks++; if (Pc !== 5'd31 || Imem_addr !== 5'd31) begin errors++; $display("FAIL wrap_pc31: got pc=%0d addr=%0d want 31 31", Pc, Imem_addr); end
        step();  // DECODE NOP
        checks++; if (Opcode !== 3'b000 || Cu_en !== 1'b1) begin errors++; $display("FAIL wrap_nop_decode: got op=%b cu_en=%b want 000 1", Opcode, Cu_en); end
        step();  // EXEC
        wb_cnt += int'(Wb_strobe);
        step();  // WB
        wb_cnt += int'(Wb_strobe);
        step();  // FETCH at 0
        wb_cnt += int'(Wb_strobe);
        checks++; if (wb_cnt !== 1) begin errors++; $display("FAIL wrap_wb_pulses: got %0d want 1", wb_cnt); end
        checks++; if (Pc !== 5'd0 || Imem_addr !== 5'd0 || Imem_req !== 1'b1) begin errors++; $display("FAIL wrap_pc0: got pc=%0d addr=%0d req=%b want 0 0 1", Pc, Imem_addr, Imem_req); end
    endtask

    // mem[0]=NOP, mem[1]=HALT -> halt with Pc=1
    task automatic test_halt();
        step(); step(); step(); step();  // DECODE, EXEC, WB, FETCH at 1
        checks++; if (Pc !== 5'd1 || Imem_addr !== 5'd1) begin errors++; $display("FAIL halt_pc1: got pc=%0d addr=%0d want 1 1", Pc, Imem_addr); end
        step();  // DECODE HALT
        checks++; if (Opcode !== 3'b111 || Cu_en !== 1'b1) begin errors++; $display("FAIL halt_decode: got op=%b cu_en=%b want 111 1", Opcode, Cu_en); end
        step();  // EXEC
        step();  // HALT
        checks++; if (Halted !== 1'b1 || Busy !== 1'b0 || Imem_req !== 1'b0) begin errors++; $display("FAIL halt_enter: got halted=%b busy=%b req=%b want 1 0 0", Halted, Busy, Imem_req); end
        for (int i = 0; i < 20; i++) begin
            step();
            checks++; if (Halted !== 1'b1 || Imem_req !== 1'b0 || Pc !== 5'd1 || Cu_en !== 1'b0 || Wb_strobe !== 1'b0) begin
                errors++; $display("FAIL halt_hold[%0d]: got halted=%b req=%b pc=%0d cu=%b wb=%b want 1 0 1 0 0", i, Halted, Imem_req, Pc, Cu_en, Wb_strobe);
            end
        end
        Run = 1'b0;
        Reset = 1'b1;
        #1;
        checks++; if (Halted !== 1'b0 || Pc !== 5'd0 || Dbg_state !== ST_IDLE) begin errors++; $display("FAIL halt_reset: got halted=%b pc=%0d state=%0d want 0 0 0", Halted, Pc, Dbg_state); end
        step();
        Reset = 1'b0;
    endtask

    // Ack delayed 3 cycles; Run dropped in EXEC; stray ack outside FETCH
    task automatic test_ack_delay_run_drop();
        mem[0] = 8'h8C;  // opcode 100, operand 12
        ack_delay = 3;
        Run = 1'b1;
        step();  // first FETCH cycle
        for (int i = 0; i < 4; i++) begin
            checks++; if (Imem_req !== 1'b1 || Imem_addr !== 5'd0 || Cu_en !== 1'b0) begin
                errors++; $display("FAIL delay_fetch[%0d]: got req=%b addr=%0d cu=%b want 1 0 0", i, Imem_req, Imem_addr, Cu_en);
            end
            step();
        end
        checks++; if (Cu_en !== 1'b1 || Imem_req !== 1'b0) begin errors++; $display("FAIL delay_decode: got cu=%b req=%b want 1 0", Cu_en, Imem_req); end
        checks++; if (Opcode !== 3'b100 || Operand !== 5'd12) begin errors++; $display("FAIL delay_ir: got op=%b opnd=%0d want 100 12", Opcode, Operand); end
        step();  // EXEC
        Run = 1'b0;
        ack_force = 1'b1; data_force_en = 1'b1; data_force = 8'hFF;
        step();  // WB
        checks++; if (Wb_strobe !== 1'b1) begin errors++; $display("FAIL drop_wb: got %b want 1", Wb_strobe); end
        step();  // IDLE
        checks++; if (Busy !== 1'b0 || Dbg_state !== ST_IDLE || Pc !== 5'd1) begin errors++; $display("FAIL drop_idle: got busy=%b state=%0d pc=%0d want 0 0 1", Busy, Dbg_state, Pc); end
        checks++; if (Opcode !== 3'b100 || Operand !== 5'd12) begin errors++; $display("FAIL stray_ack_ir: got op=%b opnd=%0d want 100 12", Opcode, Operand); end
        ack_force = 1'b0; data_force_en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (Imem_req !== 1'b0) begin errors++; $display("FAIL drop_no_req[%0d]: got %b want 0", i, Imem_req); end
        end
        ack_delay = 0;
    endtask

    // Memory never acknowledges; then Reset asserted in the middle of FETCH
    task automatic test_timeout_reset();
        ack_enable = 1'b0;
        Reset = 1'b1; step(); Reset = 1'b0;
        Run = 1'b1;
        step();  // first FETCH cycle
`ifdef SEQ_TIMEOUT_EN
        for (int i = 0; i < MAX_WAIT; i++) begin
            checks++; if (Imem_req !== 1'b1 || Fault !== 1'b0) begin errors++; $display("FAIL to_wait[%0d]: got req=%b fault=%b want 1 0", i, Imem_req, Fault); end
            step();
        end
        checks++; if (Fault !== 1'b1 || Imem_req !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL to_fault: got fault=%b req=%b busy=%b want 1 0 0", Fault, Imem_req, Busy); end
        step(); step();
        checks++; if (Fault !== 1'b1) begin errors++; $display("FAIL to_fault_hold: got %b want 1", Fault); end
        Reset = 1'b1; step(); Reset = 1'b0;
        step(); step();  // FETCH again, second cycle
`else
        for (int i = 0; i < 20; i++) begin
            checks++; if (Imem_req !== 1'b1 || Fault !== 1'b0) begin errors++; $display("FAIL wait_forever[%0d]: got req=%b fault=%b want 1 0", i, Imem_req, Fault); end
            step();
        end
`endif
        checks++; if (Imem_req !== 1'b1) begin errors++; $display("FAIL midreset_pre: got %b want 1", Imem_req); end
        Reset = 1'b1;
        #1;  // well before the next rising edge
        checks++; if (Imem_req !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL midreset_req: got req=%b busy=%b want 0 0", Imem_req, Busy); end
        step();
        Run = 1'b0;
        Reset = 1'b0;
        ack_enable = 1'b1;
    endtask

    // ---------------- main sequence and report ----------------
    initial begin
        Reset = 1'b1; Run = 1'b0;
        ack_delay = 0; ack_enable = 1'b1; ack_force = 1'b0;
        data_force_en = 1'b0; data_force = 8'h00;
        for (int i = 0; i < 32; i++) mem[i] = 8'h00;
        mem[0]  = 8'h45;
        mem[1]  = 8'h3A;
        mem[26] = 8'h3F;
        mem[31] = 8'h00;

        test_reset();
        test_alu();
        test_jmp();
        test_wrap();
        test_halt();
        test_ack_delay_run_drop();
        test_timeout_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
